// File: rtl/locator_pkg.sv
// Shared types, default widths and helpers for the bright-target locator.
package locator_pkg;

  localparam int unsigned DefCntW = 21;
  localparam int unsigned DefPosW = 13;
  localparam int unsigned DefSumW = 34;

  typedef enum logic {
    A_WAIT,
    A_ACTIVE
  } accState_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_X,
    D_Y,
    D_PUB
  } divState_t;

  // A zero minimum still requires one hit so the divisor is never zero.
  function automatic logic [63:0] effectiveMin(input logic [63:0] minCount);
    return (minCount == 64'd0) ? 64'd1 : minCount;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle after a load cycle.
// oDone marks the cycle retiring the last bit; oQuotient is final from the next cycle on.
module seq_divider import locator_pkg::*; #(
  parameter int unsigned SUM_W = DefSumW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [SUM_W-1:0] iDividend,
  input  logic [CNT_W-1:0] iDivisor,
  output logic [SUM_W-1:0] oQuotient,
  output logic             oDone
);

  localparam int unsigned IterW = $clog2(SUM_W);
  localparam logic [IterW-1:0] LastIter = IterW'(SUM_W - 1);

  logic [SUM_W-1:0] quot;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] divisor;
  logic [IterW-1:0] iter;
  logic             running;
  logic [CNT_W:0]   shifted;
  logic [CNT_W-1:0] trial;
  logic             fits;

  always_comb begin
    shifted = {rem, quot[SUM_W-1]};
    fits    = shifted >= {1'b0, divisor};
    // Only used when fits, so the true difference is below 2**CNT_W.
    trial   = shifted[CNT_W-1:0] - divisor;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      quot    <= '0;
      rem     <= '0;
      divisor <= '0;
      iter    <= '0;
      running <= 1'b0;
    end else if (iStart) begin
      quot    <= iDividend;
      rem     <= '0;
      divisor <= iDivisor;
      iter    <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem  <= fits ? trial : shifted[CNT_W-1:0];
      quot <= {quot[SUM_W-2:0], fits};
      iter <= iter + 1'b1;
      if (iter == LastIter) running <= 1'b0;
    end
  end

  assign oQuotient = quot;
  assign oDone     = running && (iter == LastIter);

endmodule

// File: rtl/target_locator.sv
// Per-frame bright-target locator: thresholded hit accumulation per frame and an
// integer centroid computed with one shared sequential divider.
module target_locator import locator_pkg::*; #(
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned POS_W = DefPosW,
  parameter int unsigned SUM_W = DefSumW
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iDVAL,
  input  logic [9:0]       iGray,
  input  logic [POS_W-1:0] iXposition,
  input  logic [POS_W-1:0] iYposition,
  input  logic             iSOF,
  input  logic             iEOF,
  input  logic [9:0]       iThreshold,
  input  logic [CNT_W-1:0] iMinCount,
  output logic [POS_W-1:0] oXresult,
  output logic [POS_W-1:0] oYresult,
  output logic             oFinished,
  output logic             oBusy,
  output logic             oOverrun
);

  accState_t        aState;
  divState_t        dState;
  logic [CNT_W-1:0] count, snapCount, closeCount;
  logic [SUM_W-1:0] sumX, sumY, snapX, snapY, closeX, closeY;
  logic             snapPend, snapOk, startY;
  logic [POS_W-1:0] xQuot;
  logic             pixHit, eofSnap, dropFrame, newHit, pendTake;
  logic             divStart, divDone;
  logic [SUM_W-1:0] divDividend, divQuot;
  logic             unusedQuotHi;

  always_comb begin
    pixHit     = iDVAL && (iGray >= iThreshold);
    closeCount = count;
    closeX     = sumX;
    closeY     = sumY;
    // A saturated count freezes the sums too, keeping the centroid consistent.
    if (aState == A_ACTIVE && pixHit && !(&count)) begin
      closeCount = count + 1'b1;
      closeX     = sumX + SUM_W'(iXposition);
      closeY     = sumY + SUM_W'(iYposition);
    end
    eofSnap     = iEOF && (aState == A_ACTIVE);
    // A snapshot still waiting to be started counts as busy as well.
    dropFrame   = eofSnap && (oBusy || snapPend);
    // On a combined SOF/EOF the pixel belongs to the closing frame only.
    newHit      = iSOF && pixHit && !eofSnap;
    pendTake    = (dState == D_IDLE) && snapPend;
    divStart    = (pendTake && snapOk) || startY;
    divDividend = startY ? snapY : snapX;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      aState    <= A_WAIT;
      count     <= '0;
      sumX      <= '0;
      sumY      <= '0;
      snapCount <= '0;
      snapX     <= '0;
      snapY     <= '0;
      snapOk    <= 1'b0;
      snapPend  <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      oOverrun <= dropFrame;
      if (pendTake) snapPend <= 1'b0;
      if (eofSnap && !dropFrame) begin
        snapCount <= closeCount;
        snapX     <= closeX;
        snapY     <= closeY;
        snapOk    <= 64'(closeCount) >= effectiveMin(64'(iMinCount));
        snapPend  <= 1'b1;
      end
      if (iSOF) begin
        aState <= A_ACTIVE;
        count  <= newHit ? CNT_W'(1) : '0;
        sumX   <= newHit ? SUM_W'(iXposition) : '0;
        sumY   <= newHit ? SUM_W'(iYposition) : '0;
      end else begin
        if (eofSnap) aState <= A_WAIT;
        count <= closeCount;
        sumX  <= closeX;
        sumY  <= closeY;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dState    <= D_IDLE;
      startY    <= 1'b0;
      xQuot     <= '0;
      oXresult  <= '0;
      oYresult  <= '0;
      oFinished <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      startY <= 1'b0;
      case (dState)
        D_IDLE: begin
          if (pendTake) begin
            if (snapOk) begin
              dState <= D_X;
              oBusy  <= 1'b1;
            end else begin
              oFinished <= 1'b0;
            end
          end
        end
        D_X: begin
          if (divDone) begin
            dState <= D_Y;
            startY <= 1'b1;
          end
        end
        D_Y: begin
          // The X quotient is still held by the divider on the Y load cycle.
          if (startY) xQuot <= divQuot[POS_W-1:0];
          if (divDone) dState <= D_PUB;
        end
        D_PUB: begin
          oXresult  <= xQuot;
          oYresult  <= divQuot[POS_W-1:0];
          oFinished <= 1'b1;
          oBusy     <= 1'b0;
          dState    <= D_IDLE;
        end
        default: dState <= D_IDLE;
      endcase
    end
  end

  assign unusedQuotHi = ^divQuot[SUM_W-1:POS_W];

  seq_divider #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W)
  ) uDivider (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iStart   (divStart),
    .iDividend(divDividend),
    .iDivisor (snapCount),
    .oQuotient(divQuot),
    .oDone    (divDone)
  );

endmodule

// File: tb/tb_target_locator.sv
// Directed bench for target_locator: centroid values, publish latency, minimum-count,
// frame boundaries, overrun and reset abort.
module tb_target_locator;

  localparam int unsigned CNT_W = 21;
  localparam int unsigned POS_W = 13;
  localparam int unsigned SUM_W = 34;

  logic             iCLK = 1'b0;
  logic             iRST, iDVAL, iSOF, iEOF;
  logic [9:0]       iGray, iThreshold;
  logic [POS_W-1:0] iXposition, iYposition;
  logic [CNT_W-1:0] iMinCount;
  logic [POS_W-1:0] oXresult, oYresult;
  logic             oFinished, oBusy, oOverrun;

  int errCount   = 0;
  int checkCount = 0;
  int busyCount;
  int ovCount;
  int finCount;

  always #5 iCLK = ~iCLK;

  target_locator #(
    .CNT_W(CNT_W),
    .POS_W(POS_W),
    .SUM_W(SUM_W)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iDVAL     (iDVAL),
    .iGray     (iGray),
    .iXposition(iXposition),
    .iYposition(iYposition),
    .iSOF      (iSOF),
    .iEOF      (iEOF),
    .iThreshold(iThreshold),
    .iMinCount (iMinCount),
    .oXresult  (oXresult),
    .oYresult  (oYresult),
    .oFinished (oFinished),
    .oBusy     (oBusy),
    .oOverrun  (oOverrun)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One pixel-clock cycle of stimulus; control pulses drop after the edge.
  task automatic cyc(input logic sof, input logic eof, input logic dval,
                     input int x, input int y, input int g);
    iSOF       = sof;
    iEOF       = eof;
    iDVAL      = dval;
    iXposition = POS_W'(x);
    iYposition = POS_W'(y);
    iGray      = 10'(g);
    tick();
    iSOF  = 1'b0;
    iEOF  = 1'b0;
    iDVAL = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0; iEOF = 1'b0;
    iGray = '0; iXposition = '0; iYposition = '0;
    iThreshold = 10'd512; iMinCount = CNT_W'(1);
    ticks(3);
    iRST = 1'b0;
    checkEq("rst_x", oXresult, 0);
    checkEq("rst_y", oYresult, 0);
    checkEq("rst_fin", oFinished, 0);
    checkEq("rst_busy", oBusy, 0);
    checkEq("rst_ovr", oOverrun, 0);

    // Single hit at (100,50); non-hits and an invalid bright pixel are ignored.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 5, 100);
    cyc(0, 0, 1, 100, 50, 900);
    cyc(0, 0, 0, 700, 700, 1000);
    cyc(0, 1, 0, 0, 0, 0);
    checkEq("t1_busy_e0", oBusy, 0);
    tick();
    checkEq("t1_busy_e1", oBusy, 1);
    ticks(69);
    checkEq("t1_x_e70", oXresult, 0);
    checkEq("t1_fin_e70", oFinished, 0);
    tick();
    checkEq("t1_x", oXresult, 100);
    checkEq("t1_y", oYresult, 50);
    checkEq("t1_fin", oFinished, 1);
    checkEq("t1_busy_end", oBusy, 0);

    // 2x2 square; gray 511 is one below threshold and must not count.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 10, 20, 600);
    cyc(0, 0, 1, 11, 20, 600);
    cyc(0, 0, 1, 900, 900, 511);
    cyc(0, 0, 1, 10, 21, 600);
    cyc(0, 0, 1, 11, 21, 600);
    cyc(0, 1, 0, 0, 0, 0);
    busyCount = 0;
    for (int k = 0; k < 75; k++) begin
      tick();
      busyCount += int'(oBusy);
    end
    checkEq("t2_busy_cycles", busyCount, 70);
    checkEq("t2_x", oXresult, 10);
    checkEq("t2_y", oYresult, 20);
    checkEq("t2_fin", oFinished, 1);

    // Four hits against a minimum of five: results hold, finished drops at E+1.
    iMinCount = CNT_W'(5);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 200, 200, 1000);
    cyc(0, 1, 0, 0, 0, 0);
    checkEq("t3_fin_e0", oFinished, 1);
    tick();
    checkEq("t3_fin_e1", oFinished, 0);
    checkEq("t3_x_hold", oXresult, 10);
    checkEq("t3_y_hold", oYresult, 20);
    busyCount = 0;
    for (int k = 0; k < 10; k++) begin
      busyCount += int'(oBusy);
      tick();
    end
    checkEq("t3_busy_never", busyCount, 0);

    // Combined SOF/EOF: (7,7) closes the old frame, the new one starts empty.
    iMinCount = '0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 30, 40, 700);
    cyc(1, 1, 1, 7, 7, 700);
    ticks(71);
    checkEq("t4_x", oXresult, 18);
    checkEq("t4_y", oYresult, 23);
    checkEq("t4_fin", oFinished, 1);
    ticks(3);
    cyc(0, 1, 0, 0, 0, 0);
    checkEq("t4_empty_fin_e0", oFinished, 1);
    tick();
    checkEq("t4_empty_fin_e1", oFinished, 0);
    checkEq("t4_empty_x_hold", oXresult, 18);
    checkEq("t4_empty_busy", oBusy, 0);

    // Second EOF at E+20 is dropped; gray equal to threshold counts.
    iMinCount = CNT_W'(1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 60, 80, 512);
    cyc(0, 0, 1, 300, 300, 511);
    cyc(0, 1, 0, 0, 0, 0);
    ovCount = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      ovCount += int'(oOverrun);
    end
    cyc(1, 0, 0, 0, 0, 0);
    ovCount += int'(oOverrun);
    cyc(0, 0, 1, 500, 500, 1000);
    ovCount += int'(oOverrun);
    for (int k = 7; k <= 19; k++) begin
      tick();
      ovCount += int'(oOverrun);
    end
    cyc(0, 1, 0, 0, 0, 0);
    checkEq("t5_ovr_pulse", oOverrun, 1);
    ovCount += int'(oOverrun);
    for (int k = 21; k <= 71; k++) begin
      tick();
      ovCount += int'(oOverrun);
    end
    checkEq("t5_ovr_count", ovCount, 1);
    checkEq("t5_x", oXresult, 60);
    checkEq("t5_y", oYresult, 80);
    checkEq("t5_fin", oFinished, 1);

    // Reset at E+30 aborts the division with no later publish.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 100, 50, 900);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(29);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    checkEq("t6_x", oXresult, 0);
    checkEq("t6_y", oYresult, 0);
    checkEq("t6_fin", oFinished, 0);
    checkEq("t6_busy", oBusy, 0);
    checkEq("t6_ovr", oOverrun, 0);
    busyCount = 0;
    finCount  = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      busyCount += int'(oBusy);
      finCount  += int'(oFinished);
    end
    checkEq("t6_no_busy", busyCount, 0);
    checkEq("t6_no_publish", finCount, 0);
    checkEq("t6_x_after", oXresult, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/target_locator.md
# target_locator

Per-frame bright-target locator. It consumes the grayscale pixel stream with its raster coordinates. It thresholds each pixel and accumulates hit count and coordinate sums over one frame. At end of frame it computes the integer centroid with a shared sequential divider. Its outputs `oXresult`, `oYresult` and `oFinished` drive the box-overlay stage in the camera display path.

## Interface
- `CNT_W`, default 21: hit-counter width; covers 1280×1024 frames.
- `POS_W`, default 13: coordinate width.
- `SUM_W`, default 34: coordinate-sum width, equal to `POS_W+CNT_W`.
- `iCLK`, in, 1: pixel clock. Single clock domain.
- `iRST`, in, 1: synchronous, active-high reset.
- `iDVAL`, in, 1: pixel valid.
- `iGray`, in, 10: grayscale pixel value.
- `iXposition`, in, `POS_W`: column of the current pixel.
- `iYposition`, in, `POS_W`: row of the current pixel.
- `iSOF`, in, 1: start-of-frame pulse, one cycle.
- `iEOF`, in, 1: end-of-frame pulse, one cycle.
- `iThreshold`, in, 10: hit when `iGray >= iThreshold`.
- `iMinCount`, in, `CNT_W`: minimum hits for a detection. 0 is treated as 1.
- `oXresult`, out, `POS_W`: centroid column.
- `oYresult`, out, `POS_W`: centroid row.
- `oFinished`, out, 1: level signal, result valid.
- `oBusy`, out, 1: division in progress.
- `oOverrun`, out, 1: one-cycle pulse when an EOF is dropped.

## Operation
- Accumulator FSM has two states, `A_WAIT` and `A_ACTIVE`.
  - `iSOF` in any state: clear count and sums, go to `A_ACTIVE`.
  - `iEOF` in `A_ACTIVE`: snapshot count and sums, go to `A_WAIT`.
  - `iEOF` in `A_WAIT`: ignored.
- Hit condition: `A_ACTIVE && iDVAL && iGray >= iThreshold`, or `iSOF && iDVAL && iGray >= iThreshold`. On a hit: count += 1, sumX += X, sumY += Y.
  - The count saturates at all-ones.
  - Once the count saturates, both sums freeze too, so the centroid stays consistent.
- Same-cycle `iSOF` and `iEOF`:
  - The EOF closes the old frame first, including any hit on that cycle.
  - The SOF then opens the new frame with cleared accumulators.
  - The pixel on that cycle is credited to the closing frame only.
- A pixel on an `iSOF`-only cycle belongs to the new frame. A pixel on an `iEOF`-only cycle belongs to the closing frame.
- Divide FSM states: `D_IDLE`, `D_X`, `D_Y`, `D_PUB`.
  - On snapshot with count ≥ max(`iMinCount`, 1): `D_IDLE` → `D_X`. Run `sumX/count`, then `D_Y` runs `sumY/count`, then `D_PUB` loads the outputs, sets `oFinished=1`, returns to `D_IDLE`.
  - On snapshot below the minimum: `oFinished` clears on the next cycle. `oXresult` and `oYresult` hold their previous values. The divide FSM stays in `D_IDLE`.
- Quotients truncate toward zero. The low `POS_W` bits are used; the true quotient always fits.
- Accumulation of the next frame runs concurrently with division.
- An `iEOF` that would snapshot while `oBusy=1`:
  - The frame is discarded and the running division is unaffected.
  - `oOverrun` pulses on the following cycle.
  - The accumulator still goes to `A_WAIT`.
- `oFinished` stays high across frames until a below-minimum frame or reset.
- `iThreshold` and `iMinCount` are sampled per cycle and per snapshot respectively. They are not latched.

## Timing
- Reset values, one cycle after `iRST` is high at an edge:
  - `oXresult=0`, `oYresult=0`, `oFinished=0`, `oBusy=0`, `oOverrun=0`.
  - Accumulator in `A_WAIT`, divider in `D_IDLE`, all accumulators 0.
- Reset during division aborts it. No publish occurs.
- Snapshot registers load at the edge ending the `iEOF` cycle E.
- `oBusy` rises at E+1. Each division takes `SUM_W` cycles plus one start cycle.
- Outputs and `oFinished` update at the edge ending cycle E+2·(`SUM_W`+1)+1, which is E+71 for defaults. `oBusy` falls on that same edge.
- Below-minimum case: `oFinished` falls at E+1.
- Accumulator update latency is one cycle. There is no back-pressure on the pixel stream.

## Structure
- Package `locator_pkg`:
  - Accumulator state enum and divide state enum.
  - Default widths.
  - A function computing the effective minimum, `max(iMinCount,1)`.
- Sub-module `seq_divider`:
  - Parameterized restoring divider, one quotient bit per cycle.
  - Ports: `iCLK`, `iRST`, `iStart`, `iDividend[SUM_W]`, `iDivisor[CNT_W]`, `oQuotient[SUM_W]`, `oDone` (one-cycle pulse).
  - Instantiated once and shared between X and Y.
- Top level holds both FSMs, the accumulators, the snapshot registers and the output registers.

## Test plan
- Single-hit frame: SOF; one pixel at (100,50) with gray 900 and threshold 512; EOF → `oXresult=100`, `oYresult=50`, `oFinished=1` exactly 71 cycles after the EOF cycle.
- Square frame: hits at (10,20), (11,20), (10,21), (11,21) → result (10,20) by truncation, `oBusy` high for 70 cycles.
- Minimum not met: `iMinCount=5` with 4 hits after a valid prior result → `oFinished` falls at E+1, results hold (10,20), `oBusy` stays 0.
- Same-cycle boundary: SOF and EOF on the same cycle with a hit at (7,7) → the closing frame includes (7,7) and the new frame's count is 0.
- Overrun: second EOF arrives 20 cycles after the first → `oOverrun` pulses once and the first frame's result publishes unchanged.
- Reset mid-division: `iRST` high at E+30 → all outputs 0 at the next cycle and no later publish.
